max_frame_sched: RTL and testbench

Sequential controller that owns one shared pairwise max unit and schedules it over a stream of operands. The unit reduces each frame of up to FRAME_LEN words to a single maximum. It sits between an upstream valid/ready producer and a downstream valid/ready consumer. It is the stateful wrapper around the combinational max datapath partitions, and can run that datapath in exact or approximate form.

---
 rtl/max_sched_pkg.sv | 19 +
 rtl/max_cmp_unit.sv | 19 +
 rtl/max_frame_sched.sv | 77 +++++++
 tb/tb_max_frame_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/max_sched_pkg.sv
// Shared types and defaults for the frame-max scheduler.
// Optional build macro APPROX_MAX_EN (consumed by max_cmp_unit) selects the approximate max.
package max_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    localparam int DEF_W         = 4;
    localparam int DEF_FRAME_LEN = 8;

    // Counter must hold FRAME_LEN itself, not just FRAME_LEN-1.
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/max_cmp_unit.sv
// Combinational pairwise max. Build macro APPROX_MAX_EN: compare on bits [W-1:1]
// only and tie the result LSB to zero; otherwise exact unsigned max, ties keep a.
module max_cmp_unit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

`ifdef APPROX_MAX_EN
    logic unused_lsb;
    assign unused_lsb = a[0] ^ b[0];
    assign y = (b[W-1:1] > a[W-1:1]) ? {b[W-1:1], 1'b0} : {a[W-1:1], 1'b0};
`else
    assign y = (b > a) ? b : a;
`endif

endmodule

// File: rtl/max_frame_sched.sv
// Frame-max controller: reduces up to FRAME_LEN words per frame through one shared
// max_cmp_unit. Build macro APPROX_MAX_EN switches that unit to approximate mode.
module max_frame_sched
    import max_sched_pkg::*;
#(
    parameter int  W         = DEF_W,
    parameter int  FRAME_LEN = DEF_FRAME_LEN,
    localparam int CNT_W     = cnt_width(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [W-1:0]     acc_q, cmp_a, max_val;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             accept, term;

    // Feeding zero on the first word lets the same unit load the accumulator,
    // which also applies the approximate-mode LSB masking to that word.
    assign cmp_a = (state_q == IDLE) ? '0 : acc_q;

    max_cmp_unit #(.W(W)) u_max (
        .a (cmp_a),
        .b (in_data),
        .y (max_val)
    );

    assign accept  = in_valid && in_ready;
    assign cnt_nxt = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign term    = in_last || (cnt_nxt == CNT_W'(FRAME_LEN));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE, ACC: begin
                in_ready = 1'b1;
                if (in_valid) state_d = term ? HOLD : ACC;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_q <= max_val;
                cnt_q <= cnt_nxt;
            end
        end
    end

    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_max_frame_sched.sv
// Scoreboard bench for max_frame_sched: FRAME_LEN=4 and FRAME_LEN=1 instances, W=4.
// Expected results follow APPROX_MAX_EN when the bench is built with it.
module tb_max_frame_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1, sel = 1'b0;
    logic [3:0] in_data = '0;

    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_out_valid, a_busy;
    logic [3:0] a_out_data;
    logic [2:0] a_out_count;
    logic       b_in_valid, b_in_ready, b_out_valid, b_busy;
    logic [3:0] b_out_data;
    logic [0:0] b_out_count;
    logic       cur_ready;

    assign a_in_valid = in_valid && !sel;
    assign b_in_valid = in_valid && sel;
    assign cur_ready  = sel ? b_in_ready : a_in_ready;

    max_frame_sched #(.W(4), .FRAME_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .out_count(a_out_count),
        .busy(a_busy)
    );

    max_frame_sched #(.W(4), .FRAME_LEN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data), .out_count(b_out_count),
        .busy(b_busy)
    );

    int n_vec = 0, n_bad = 0;
    int qa_d[$], qa_c[$], qb_d[$], qb_c[$];

    function automatic int ev(input int exact, input int approx);
`ifdef APPROX_MAX_EN
        return approx;
`else
        return exact;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && a_out_valid && out_ready) begin
            if (qa_d.size() == 0) begin
                n_bad++;
                $display("FAIL a_unexpected_result: got %0d, expected none", a_out_data);
            end else begin
                check("a_out_data", int'(a_out_data), qa_d.pop_front());
                check("a_out_count", int'(a_out_count), qa_c.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && out_ready) begin
            if (qb_d.size() == 0) begin
                n_bad++;
                $display("FAIL b_unexpected_result: got %0d, expected none", b_out_data);
            end else begin
                check("b_out_data", int'(b_out_data), qb_d.pop_front());
                check("b_out_count", int'(b_out_count), qb_c.pop_front());
            end
        end
    end

    // Present one word and hold it until the selected DUT accepts it.
    task automatic send(input int d, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = 4'(d);
        in_last  = last;
        @(negedge clk);
        while (!cur_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready) begin
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        @(negedge clk);
        while (!(a_in_ready && !a_out_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a_idle_timeout", int'(a_in_ready && !a_out_valid), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #11;
        check("rst_in_ready", int'(a_in_ready), 1);
        check("rst_out_valid", int'(a_out_valid), 0);
        check("rst_out_data", int'(a_out_data), 0);
        check("rst_out_count", int'(a_out_count), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_b_out_valid", int'(b_out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full frame, back-to-back, with latency check
        qa_d.push_back(ev(9, 8)); qa_c.push_back(4);
        send(3, 0); send(9, 0);
        check("busy_mid_frame", int'(a_busy), 1);
        send(5, 0); send(7, 0);
        @(negedge clk);
        check("latency_out_valid", int'(a_out_valid), 1);
        check("hold_in_ready", int'(a_in_ready), 0);
        @(negedge clk);
        check("post_take_in_ready", int'(a_in_ready), 1);
        check("post_take_out_valid", int'(a_out_valid), 0);
        check("post_take_busy", int'(a_busy), 0);
        @(posedge clk);
        #1;

        // Tie on the upper bits (approx keeps acc)
        qa_d.push_back(ev(9, 8)); qa_c.push_back(2);
        send(9, 0); send(8, 1);

        // Short frame then a full one
        qa_d.push_back(12); qa_c.push_back(2);
        send(12, 0); send(4, 1);
        qa_d.push_back(ev(15, 14)); qa_c.push_back(4);
        send(1, 0); send(2, 0); send(3, 0); send(15, 0);

        // in_last coinciding with the FRAME_LEN-th word
        qa_d.push_back(10); qa_c.push_back(4);
        send(2, 0); send(6, 0); send(10, 0); send(1, 1);

        // Backpressure in HOLD
        wait_idle_a();
        out_ready = 1'b0;
        qa_d.push_back(ev(13, 12)); qa_c.push_back(2);
        send(13, 0); send(2, 1);
        in_valid = 1'b1;
        in_data  = 4'd15;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(a_out_valid), 1);
            check("bp_out_data", int'(a_out_data), ev(13, 12));
            check("bp_out_count", int'(a_out_count), 2);
            check("bp_in_ready", int'(a_in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", int'(a_in_ready), 1);
        check("bp_release_out_valid", int'(a_out_valid), 0);
        @(posedge clk);
        #1;
        qa_d.push_back(ev(1, 0)); qa_c.push_back(1);
        send(1, 1);

        // Asynchronous reset mid-frame
        wait_idle_a();
        send(7, 0); send(14, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(a_out_valid), 0);
        check("arst_out_data", int'(a_out_data), 0);
        check("arst_in_ready", int'(a_in_ready), 1);
        check("arst_busy", int'(a_busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        qa_d.push_back(4); qa_c.push_back(4);
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);

        // FRAME_LEN=1 instance
        wait_idle_a();
        sel = 1'b1;
        qb_d.push_back(ev(5, 4));   qb_c.push_back(1);
        qb_d.push_back(ev(11, 10)); qb_c.push_back(1);
        send(5, 0);
        @(negedge clk);
        check("b_hold_out_valid", int'(b_out_valid), 1);
        check("b_hold_in_ready", int'(b_in_ready), 0);
        check("b_hold_busy", int'(b_busy), 1);
        send(11, 0);

        for (int i = 0; i < 20; i++) begin
            if (qa_d.size() == 0 && qb_d.size() == 0) break;
            @(negedge clk);
        end
        check("a_queue_drained", qa_d.size(), 0);
        check("b_queue_drained", qb_d.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
